// File: rtl/bus_arbiter3.sv
// Round-robin arbiter for three bus masters with tenure-limited pre-emption.
// All outputs are registered; every ownership change passes through one IDLE cycle.
//
// state | meaning
// IDLE  | no grant, bus turnaround; msel holds the last owner's code
// OWN   | one master granted; tenure timer running
module bus_arbiter3 #(
  parameter int MAX_TENURE = 64,
  parameter int CW         = $clog2(MAX_TENURE + 1)
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [2:0] req,
  input  logic       ack,
  output logic [2:0] gnt,
  output logic [1:0] msel,
  output logic       bus_busy
);

  typedef enum logic {IDLE, OWN} state_t;

  state_t        state, state_nx;
  logic [2:0]    gnt_nx;
  logic [1:0]    msel_nx;
  logic          busy_nx;
  logic [1:0]    last, last_nx;
  logic [1:0]    win;
  logic [CW-1:0] rem, rem_nx;
  logic          own_req, other_req, tenure_done, release_bus;

  // Tenure is a down-counter: rem reaching zero means cnt has hit MAX_TENURE.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      gnt      <= 3'b000;
      msel     <= 2'd0;
      bus_busy <= 1'b0;
      last     <= 2'd2;
      rem      <= '0;
    end else begin
      state    <= state_nx;
      gnt      <= gnt_nx;
      msel     <= msel_nx;
      bus_busy <= busy_nx;
      last     <= last_nx;
      rem      <= rem_nx;
    end
  end

  // Scan order starts just after the most recent owner.
  always_comb begin
    win = 2'd0;
    case (last)
      2'd0: begin
        if (req[1])      win = 2'd1;
        else if (req[2]) win = 2'd2;
        else             win = 2'd0;
      end
      2'd1: begin
        if (req[2])      win = 2'd2;
        else if (req[0]) win = 2'd0;
        else             win = 2'd1;
      end
      default: begin
        if (req[0])      win = 2'd0;
        else if (req[1]) win = 2'd1;
        else             win = 2'd2;
      end
    endcase
  end

  assign own_req     = |(req & gnt);
  assign other_req   = |(req & ~gnt);
  assign tenure_done = (rem == '0);
  assign release_bus = !own_req || (ack && tenure_done && other_req);

  always_comb begin
    state_nx = state;
    gnt_nx   = gnt;
    msel_nx  = msel;
    busy_nx  = bus_busy;
    last_nx  = last;
    rem_nx   = rem;
    case (state)
      IDLE: begin
        if (|req) begin
          state_nx = OWN;
          gnt_nx   = 3'b001 << win;
          msel_nx  = win;
          busy_nx  = 1'b1;
          last_nx  = win;
          rem_nx   = CW'(MAX_TENURE);
        end
      end
      OWN: begin
        if (!tenure_done) rem_nx = rem - CW'(1);
        if (release_bus) begin
          state_nx = IDLE;
          gnt_nx   = 3'b000;
          busy_nx  = 1'b0;
        end
      end
      default: begin
        state_nx = IDLE;
        gnt_nx   = 3'b000;
        busy_nx  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_bus_arbiter3.sv
// Directed bench for bus_arbiter3 with MAX_TENURE = 4; expected values worked out by hand.
module tb_bus_arbiter3;

  logic       clk = 1'b0;
  logic       rstn = 1'b1;
  logic [2:0] req = 3'b000;
  logic       ack = 1'b0;
  logic [2:0] gnt;
  logic [1:0] msel;
  logic       bus_busy;

  int n_vec = 0;
  int n_err = 0;

  bus_arbiter3 #(.MAX_TENURE(4)) dut (
    .clk(clk), .rstn(rstn), .req(req), .ack(ack),
    .gnt(gnt), .msel(msel), .bus_busy(bus_busy)
  );

  always #5 clk = ~clk;

  // Observed word is {bus_busy, msel, gnt}.
  task automatic chk(input string tag, input logic [5:0] exp);
    logic [5:0] obs;
    obs = {bus_busy, msel, gnt};
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed busy/msel/gnt=%b/%b/%b expected %b/%b/%b",
             tag, obs[5], obs[4:3], obs[2:0], exp[5], exp[4:3], exp[2:0]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rstn === 1'b1) begin
      n_vec++;
      assert ($onehot0(gnt) && msel !== 2'b11) else begin
        n_err++;
        $error("FAIL onehot: observed gnt=%b msel=%b expected at most one gnt bit and msel!=11", gnt, msel);
      end
    end
  end

  initial begin
    #1 rstn = 1'b0;
    tick();
    chk("reset_state", 6'b0_00_000);

    rstn = 1'b1;
    req  = 3'b111;
    tick(); chk("first_grant_m0", 6'b1_00_001);

    // Round-robin: each owner drops req for one cycle after holding a few cycles.
    tick(); tick(); chk("m0_held", 6'b1_00_001);
    req = 3'b110; tick(); chk("rr_idle0", 6'b0_00_000);
    req = 3'b111; tick(); chk("rr_grant_m1", 6'b1_01_010);
    tick(); tick();
    req = 3'b101; tick(); chk("rr_idle1", 6'b0_01_000);
    req = 3'b111; tick(); chk("rr_grant_m2", 6'b1_10_100);
    tick(); tick();
    req = 3'b011; tick(); chk("rr_idle2", 6'b0_10_000);
    req = 3'b111; tick(); chk("rr_grant_m0", 6'b1_00_001);

    // Asynchronous reset mid-tenure while master1 owns.
    req = 3'b110; tick(); chk("pre_rst_idle", 6'b0_00_000);
    tick(); chk("pre_rst_m1", 6'b1_01_010);
    #3 rstn = 1'b0;
    #1 chk("async_reset", 6'b0_00_000);
    @(posedge clk); #1;
    rstn = 1'b1;
    req  = 3'b111;
    tick(); chk("post_rst_m0", 6'b1_00_001);

    // Pre-emption: master0 owns since the last edge (cnt=0), master1 waits.
    req = 3'b011;
    tick(); tick();
    ack = 1'b1; tick(); ack = 1'b0; chk("ack_cnt2_hold", 6'b1_00_001);
    ack = 1'b1; tick(); ack = 1'b0; chk("ack_cnt3_hold", 6'b1_00_001);
    ack = 1'b1; tick(); ack = 1'b0; chk("preempt_idle", 6'b0_00_000);
    tick(); chk("preempt_grant_m1", 6'b1_01_010);

    // Simultaneous release and qualifying ack.
    tick(); tick(); tick(); tick(); chk("m1_tenure_full", 6'b1_01_010);
    req = 3'b001; ack = 1'b1; tick(); ack = 1'b0; chk("simul_idle", 6'b0_01_000);
    tick(); chk("simul_grant_m0", 6'b1_00_001);

    // Lone requester keeps the bus past MAX_TENURE despite ack pulses.
    req = 3'b000; tick(); chk("lone_idle", 6'b0_00_000);
    req = 3'b100; tick(); chk("lone_grant_m2", 6'b1_10_100);
    for (int i = 0; i < 8; i++) begin
      ack = i[0];
      tick();
    end
    ack = 1'b0;
    chk("lone_held", 6'b1_10_100);

    // Late requester: master2 raises while master0 owns; no effect until release.
    req = 3'b000; tick(); chk("late_idle0", 6'b0_10_000);
    req = 3'b001; tick(); chk("late_grant_m0", 6'b1_00_001);
    req = 3'b101; tick(); tick(); chk("late_no_effect", 6'b1_00_001);
    req = 3'b100; tick(); chk("late_idle1", 6'b0_00_000);
    tick(); chk("late_grant_m2", 6'b1_10_100);
    req = 3'b110; tick(); tick(); chk("late_m1_no_effect", 6'b1_10_100);
    req = 3'b010; tick(); chk("late_idle2", 6'b0_10_000);
    tick(); chk("late_grant_m1", 6'b1_01_010);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
